// File: rtl/bit_pop_pkg.sv
// bit_pop_pkg: width helpers shared by the population counter and its chunk counters
package bit_pop_pkg;
    function automatic int cw_of(input int width);
        return $clog2(width) + 2;
    endfunction
    function automatic int cnt_w_of(input int chunk);
        return $clog2(chunk) + 1;
    endfunction
endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk: combinational count of set bits in one CHUNK-bit slice
module popcount_chunk
    import bit_pop_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0]              bits_i,
    output logic [cnt_w_of(CHUNK)-1:0]    cnt_o
);
    localparam int KW = cnt_w_of(CHUNK);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < CHUNK; i++) cnt_o = cnt_o + KW'(bits_i[i]);
    end
endmodule

// File: rtl/bit_pop_counter.sv
// bit_pop_counter: two-stage pipelined population counter, one word per clock
module bit_pop_counter
    import bit_pop_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    input  logic                       data_val_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       data_val_o,
    output logic [cw_of(WIDTH)-1:0]    data_o
);
    localparam int CW = cw_of(WIDTH);
    localparam int KW = cnt_w_of(CHUNK);
    localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
    logic [N*CHUNK-1:0] pad;
    logic [KW-1:0]      raw [N];
    logic [KW-1:0]      cnt_d [N];
    logic [KW-1:0]      cnt_q [N];
    logic               val_q;
    logic [CW-1:0]      sum_d;
    logic [CW-1:0]      data_q;
    logic               data_val_q;
    // last chunk is zero-padded on the MSB side
    assign pad = (N*CHUNK)'(data_i);
    for (genvar g = 0; g < N; g++) begin : g_chunk
        popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
            .bits_i (pad[g*CHUNK +: CHUNK]),
            .cnt_o  (raw[g])
        );
        assign cnt_d[g] = data_val_i ? raw[g] : '0;
    end
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) sum_d = sum_d + CW'(cnt_q[i]);
    end
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q      <= '{default: '0};
            val_q      <= 1'b0;
            data_q     <= '0;
            data_val_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            val_q      <= data_val_i;
            data_q     <= sum_d;
            data_val_q <= val_q;
        end
    end
    assign data_o     = data_q;
    assign data_val_o = data_val_q;
endmodule

// File: tb/tb_bit_pop_counter.sv
// tb_bit_pop_counter: directed and random checks of the pipelined popcount
module tb_bit_pop_counter;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        val = 1'b0;
    logic [31:0] din = '0;
    logic        vout;
    logic [6:0]  dout;
    logic        val7 = 1'b0;
    logic [6:0]  din7 = '0;
    logic        vout7;
    logic [4:0]  dout7;
    logic        val1 = 1'b0;
    logic [0:0]  din1 = '0;
    logic        vout1;
    logic [1:0]  dout1;
    int          total = 0;
    int          bad = 0;
    int          eq[$];
    logic        vq[$];
    string       tq[$];

    always #5 clk = ~clk;

    bit_pop_counter #(.WIDTH(32), .CHUNK(4)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .data_val_i(val), .data_i(din),
        .data_val_o(vout), .data_o(dout)
    );
    bit_pop_counter #(.WIDTH(7), .CHUNK(4)) dut7 (
        .clk_i(clk), .arst_n_i(arst_n), .data_val_i(val7), .data_i(din7),
        .data_val_o(vout7), .data_o(dout7)
    );
    bit_pop_counter #(.WIDTH(1), .CHUNK(4)) dut1 (
        .clk_i(clk), .arst_n_i(arst_n), .data_val_i(val1), .data_i(din1),
        .data_val_o(vout1), .data_o(dout1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // each call checks the word driven two calls earlier, then drives a new one
    task automatic cyc(input logic v, input logic [31:0] d, input int e, input string tag);
        @(negedge clk);
        if (eq.size() == 2) begin
            check({tq[0], "_cnt"}, 32'(dout), 32'(eq[0]));
            check({tq[0], "_val"}, 32'(vout), 32'(vq[0]));
            void'(eq.pop_front());
            void'(vq.pop_front());
            void'(tq.pop_front());
        end
        val = v;
        din = d;
        eq.push_back(v ? e : 0);
        vq.push_back(v);
        tq.push_back(tag);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        #12;
        check("rst_cnt", 32'(dout), 0);
        check("rst_val", 32'(vout), 0);
        @(negedge clk);
        arst_n = 1'b1;
        // parameter variants: padded width 7 and single-bit width
        @(negedge clk);
        val7 = 1'b1; din7 = 7'h7F; val1 = 1'b1; din1 = 1'b1;
        @(negedge clk);
        val7 = 1'b0; din7 = 7'h55; val1 = 1'b0; din1 = 1'b1;
        @(negedge clk);
        check("w7_cnt", 32'(dout7), 7);
        check("w7_val", 32'(vout7), 1);
        check("w1_cnt", 32'(dout1), 1);
        check("w1_val", 32'(vout1), 1);
        @(negedge clk);
        check("w7_idle_cnt", 32'(dout7), 0);
        check("w7_idle_val", 32'(vout7), 0);
        check("w1_idle_cnt", 32'(dout1), 0);
        check("w1_idle_val", 32'(vout1), 0);
        for (int n = 0; n <= 32; n++) begin
            d = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
            cyc(n != 0, d, n, "thermo");
        end
        cyc(1'b1, 32'h0000_0001, 1, "b2b");
        cyc(1'b1, 32'h8000_0000, 1, "b2b");
        cyc(1'b1, 32'hF0F0_F0F0, 16, "b2b");
        cyc(1'b1, 32'hFFFF_FFFF, 32, "b2b");
        cyc(1'b1, 32'h0000_00FF, 8, "bubble");
        cyc(1'b0, 32'hABCD_1234, 0, "bubble");
        cyc(1'b1, 32'h0000_0003, 2, "bubble");
        cyc(1'b1, 32'h0000_00FF, 8, "pre_rst");
        cyc(1'b1, 32'hFFFF_FFFF, 32, "pre_rst");
        cyc(1'b1, 32'hFFFF_FFFF, 32, "pre_rst");
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(dout), 0);
        check("async_rst_val", 32'(vout), 0);
        eq.delete(); vq.delete(); tq.delete();
        @(negedge clk);
        val = 1'b0;
        din = '0;
        @(negedge clk);
        arst_n = 1'b1;
        check("post_rst_cnt", 32'(dout), 0);
        check("post_rst_val", 32'(vout), 0);
        cyc(1'b0, 32'h0000_0000, 0, "no_stale");
        cyc(1'b1, 32'h0000_0007, 3, "post_rst");
        cyc(1'b0, 32'hFFFF_FFFF, 0, "post_rst");
        for (int i = 0; i < 1000; i++) begin
            v = 1'($urandom_range(0, 1));
            d = $urandom;
            cyc(v, d, $countones(d), "rnd");
        end
        cyc(1'b0, 0, 0, "flush");
        cyc(1'b0, 0, 0, "flush");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
